// File: rtl/axi_perf_mon_pkg.sv
// Shared types for the AXI performance monitor sequencer: FSM state, status bit map, snapshot record.
package axi_perf_mon_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CLEAR   = 4'd1,
        S_ARM     = 4'd2,
        S_RUN     = 4'd3,
        S_STOP    = 4'd4,
        S_SETTLE  = 4'd5,
        S_CAPTURE = 4'd6
    } t_pmc_state;

    localparam int STAT_CONT    = 4;
    localparam int STAT_BUSY    = 5;
    localparam int STAT_DONE    = 6;
    localparam int STAT_ABORTED = 7;

    typedef struct packed {
        logic [31:0] bw_rd;
        logic [31:0] bw_wr;
        logic [31:0] lat_avg;
        logic [31:0] lat_max;
        logic [31:0] lat_min;
    } t_pmc_snapshot;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi_perf_mon_snapshot.sv
// Snapshot bank: five result registers plus saturating capture counter.
// Loads one cycle after i_load is seen; no backpressure, clear wins over load.
module axi_perf_mon_snapshot
    import axi_perf_mon_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_load,
    input  logic          i_clear,
    input  t_pmc_snapshot i_data,
    output t_pmc_snapshot o_snap,
    output logic [15:0]   o_run_count
);

    t_pmc_snapshot r_snap;
    logic [15:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            r_snap  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_snap  <= i_data;
            r_count <= sat_inc16(r_count);
        end
    end

    assign o_snap      = r_snap;
    assign o_run_count = r_count;

endmodule

// File: rtl/axi_perf_mon_ctrl.sv
// Measurement sequencer: clear -> arm -> run -> stop -> settle -> capture, single-shot or repeating.
// Start strobe CLR_CYCLES+1 cycles after command; commands are pulses, never stalled.
module axi_perf_mon_ctrl
    import axi_perf_mon_pkg::*;
#(
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int DUR_WIDTH     = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_cmd_start,
    input  logic                 i_cmd_stop,
    input  logic                 i_cmd_clear,
    input  logic                 i_continuous,
    input  logic [DUR_WIDTH-1:0] i_duration,
    input  logic [31:0]          i_bw_rd,
    input  logic [31:0]          i_bw_wr,
    input  logic [31:0]          i_lat_avg,
    input  logic [31:0]          i_lat_max,
    input  logic [31:0]          i_lat_min,
    output logic                 o_mon_start,
    output logic                 o_mon_stop,
    output logic                 o_mon_counter_reset,
    output logic [31:0]          o_snap_bw_rd,
    output logic [31:0]          o_snap_bw_wr,
    output logic [31:0]          o_snap_lat_avg,
    output logic [31:0]          o_snap_lat_max,
    output logic [31:0]          o_snap_lat_min,
    output logic [DUR_WIDTH-1:0] o_elapsed,
    output logic [15:0]          o_run_count,
    output logic [31:0]          o_status
);

    localparam logic [7:0]           CLR_LAST    = 8'(CLR_CYCLES - 1);
    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [DUR_WIDTH-1:0] DUR_ONE     = DUR_WIDTH'(1);

    t_pmc_state           r_state;
    logic [7:0]           r_cnt;
    logic [DUR_WIDTH-1:0] r_dur;
    logic [DUR_WIDTH-1:0] r_elapsed;
    logic                 r_mon_start;
    logic                 r_mon_stop;
    logic                 r_cnt_rst;
    logic                 r_aborted;
    logic                 r_done;
    logic                 r_cont;
    logic                 r_stop_req;

    logic                 w_run_end;
    logic [DUR_WIDTH-1:0] w_elapsed_inc;
    logic                 w_cap_load;
    logic                 w_snap_clear;
    t_pmc_snapshot        w_cap_data;
    t_pmc_snapshot        w_snap;
    logic [31:0]          w_status;

    assign w_elapsed_inc = (&r_elapsed) ? r_elapsed : r_elapsed + DUR_ONE;
    assign w_run_end     = i_cmd_stop || ((r_dur != '0) && (r_elapsed == r_dur - DUR_ONE));
    assign w_cap_load    = (r_state == S_CAPTURE);
    assign w_snap_clear  = (r_state == S_IDLE) && i_cmd_clear;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dur       <= '0;
            r_elapsed   <= '0;
            r_mon_start <= 1'b0;
            r_mon_stop  <= 1'b0;
            r_cnt_rst   <= 1'b0;
            r_aborted   <= 1'b0;
            r_done      <= 1'b0;
            r_cont      <= 1'b0;
            r_stop_req  <= 1'b0;
        end else begin
            r_mon_start <= 1'b0;
            r_mon_stop  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_clear)
                        r_done <= 1'b0;
                    if (i_cmd_start && !i_cmd_stop) begin
                        r_state    <= S_CLEAR;
                        r_cnt      <= '0;
                        r_cnt_rst  <= 1'b1;
                        r_dur      <= i_duration;
                        r_elapsed  <= '0;
                        r_aborted  <= 1'b0;
                        r_done     <= 1'b0;
                        r_cont     <= i_continuous;
                        r_stop_req <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (i_cmd_stop) begin
                        r_state   <= S_IDLE;
                        r_cnt_rst <= 1'b0;
                        r_aborted <= 1'b1;
                        r_cont    <= 1'b0;
                    end else if (r_cnt == CLR_LAST) begin
                        r_state   <= S_ARM;
                        r_cnt_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                // The start strobe is issued on the way out of ARM so a stop seen here can still suppress it.
                S_ARM: begin
                    if (i_cmd_stop) begin
                        r_state   <= S_IDLE;
                        r_aborted <= 1'b1;
                        r_cont    <= 1'b0;
                    end else begin
                        r_mon_start <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_elapsed <= w_elapsed_inc;
                    if (i_cmd_stop)
                        r_stop_req <= 1'b1;
                    if (w_run_end)
                        r_state <= S_STOP;
                end
                S_STOP: begin
                    r_mon_stop <= 1'b1;
                    r_state    <= S_SETTLE;
                    r_cnt      <= '0;
                    if (i_cmd_stop)
                        r_stop_req <= 1'b1;
                end
                S_SETTLE: begin
                    if (i_cmd_stop)
                        r_stop_req <= 1'b1;
                    if (r_cnt == SETTLE_LAST)
                        r_state <= S_CAPTURE;
                    else
                        r_cnt <= r_cnt + 8'd1;
                end
                S_CAPTURE: begin
                    r_done <= 1'b1;
                    if (i_continuous && !i_cmd_stop && !r_stop_req) begin
                        r_state   <= S_CLEAR;
                        r_cnt     <= '0;
                        r_cnt_rst <= 1'b1;
                        r_dur     <= i_duration;
                        r_elapsed <= '0;
                        r_cont    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_cont  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_cap_data = '{bw_rd: i_bw_rd, bw_wr: i_bw_wr, lat_avg: i_lat_avg,
                          lat_max: i_lat_max, lat_min: i_lat_min};

    axi_perf_mon_snapshot u_snap (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_load      (w_cap_load),
        .i_clear     (w_snap_clear),
        .i_data      (w_cap_data),
        .o_snap      (w_snap),
        .o_run_count (o_run_count)
    );

    always_comb begin
        w_status               = '0;
        w_status[3:0]          = r_state;
        w_status[STAT_CONT]    = r_cont;
        w_status[STAT_BUSY]    = (r_state != S_IDLE);
        w_status[STAT_DONE]    = r_done;
        w_status[STAT_ABORTED] = r_aborted;
    end

    assign o_mon_start         = r_mon_start;
    assign o_mon_stop          = r_mon_stop;
    assign o_mon_counter_reset = r_cnt_rst;
    assign o_snap_bw_rd        = w_snap.bw_rd;
    assign o_snap_bw_wr        = w_snap.bw_wr;
    assign o_snap_lat_avg      = w_snap.lat_avg;
    assign o_snap_lat_max      = w_snap.lat_max;
    assign o_snap_lat_min      = w_snap.lat_min;
    assign o_elapsed           = r_elapsed;
    assign o_status            = w_status;

endmodule

// File: tb/tb_axi_perf_mon_ctrl.sv
// Bench for axi_perf_mon_ctrl: vector table, randomized single shots, and hand-built corner sequences.
module tb_axi_perf_mon_ctrl;

    localparam int CLR = 4;
    localparam int SET = 16;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cmd_start, i_cmd_stop, i_cmd_clear, i_continuous;
    logic [DW-1:0] i_duration;
    logic [31:0]   i_bw_rd, i_bw_wr, i_lat_avg, i_lat_max, i_lat_min;
    logic          o_mon_start, o_mon_stop, o_mon_counter_reset;
    logic [31:0]   o_snap_bw_rd, o_snap_bw_wr, o_snap_lat_avg, o_snap_lat_max, o_snap_lat_min;
    logic [DW-1:0] o_elapsed;
    logic [15:0]   o_run_count;
    logic [31:0]   o_status;

    axi_perf_mon_ctrl #(.CLR_CYCLES(CLR), .SETTLE_CYCLES(SET), .DUR_WIDTH(DW)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_start(i_cmd_start), .i_cmd_stop(i_cmd_stop), .i_cmd_clear(i_cmd_clear),
        .i_continuous(i_continuous), .i_duration(i_duration),
        .i_bw_rd(i_bw_rd), .i_bw_wr(i_bw_wr),
        .i_lat_avg(i_lat_avg), .i_lat_max(i_lat_max), .i_lat_min(i_lat_min),
        .o_mon_start(o_mon_start), .o_mon_stop(o_mon_stop), .o_mon_counter_reset(o_mon_counter_reset),
        .o_snap_bw_rd(o_snap_bw_rd), .o_snap_bw_wr(o_snap_bw_wr),
        .o_snap_lat_avg(o_snap_lat_avg), .o_snap_lat_max(o_snap_lat_max), .o_snap_lat_min(o_snap_lat_min),
        .o_elapsed(o_elapsed), .o_run_count(o_run_count), .o_status(o_status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log: edge number at which each strobe / capture state became visible.
    int q_start[$];
    int q_stop[$];
    int q_cap[$];
    int n_crst;
    always @(posedge clk) begin
        #2;
        if (o_mon_start) q_start.push_back(cyc);
        if (o_mon_stop) q_stop.push_back(cyc);
        if (o_status[3:0] == 4'd6) q_cap.push_back(cyc);
        if (o_mon_counter_reset) n_crst++;
    end

    int total = 0;
    int bad   = 0;
    int t_start;

    // Reference model: what software should read back after each completed capture.
    int          m_count;
    logic [31:0] m_snap[5];

    typedef struct {
        int          dur;
        logic [31:0] bw_rd;
        int          exp_start;
        int          exp_stop;
        int          exp_cap;
        int          exp_elapsed;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_mon();
        q_start.delete(); q_stop.delete(); q_cap.delete(); n_crst = 0;
    endtask

    task automatic set_data(input logic [31:0] d0);
        i_bw_rd = d0; i_bw_wr = $urandom; i_lat_avg = $urandom; i_lat_max = $urandom; i_lat_min = $urandom;
    endtask

    task automatic model_capture();
        if (m_count < 65535) m_count++;
        m_snap = '{i_bw_rd, i_bw_wr, i_lat_avg, i_lat_max, i_lat_min};
    endtask

    task automatic model_zero();
        m_count = 0;
        m_snap  = '{0, 0, 0, 0, 0};
    endtask

    task automatic check_snaps(input string tag);
        logic [31:0] act[5];
        act = '{o_snap_bw_rd, o_snap_bw_wr, o_snap_lat_avg, o_snap_lat_max, o_snap_lat_min};
        for (int i = 0; i < 5; i++) check($sformatf("%s_snap%0d", tag, i), act[i], m_snap[i]);
        check({tag, "_runcnt"}, o_run_count, m_count);
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) i_cmd_start = 1'b1;
        if (which == 1) i_cmd_stop = 1'b1;
        if (which == 2) i_cmd_clear = 1'b1;
        if (which == 0) t_start = cyc + 1;
        @(negedge clk);
        i_cmd_start = 1'b0; i_cmd_stop = 1'b0; i_cmd_clear = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_status[3:0] == 4'd0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q_start.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_run(input int dur, input logic [31:0] d0, input int es, input int ep,
                          input int ec, input int ee, input string tag);
        bit ok;
        i_duration = dur; set_data(d0); clear_mon();
        pulse(0);
        wait_idle(3000, ok);
        check({tag, "_done_in_time"}, ok, 1);
        model_capture();
        check({tag, "_nstart"}, q_start.size(), 1);
        check({tag, "_start_lat"}, qat(q_start, 0) - t_start, es);
        check({tag, "_nstop"}, q_stop.size(), 1);
        check({tag, "_stop_lat"}, qat(q_stop, 0) - t_start, ep);
        check({tag, "_ncap"}, q_cap.size(), 1);
        check({tag, "_cap_lat"}, qat(q_cap, 0) - t_start, ec);
        check({tag, "_crst_cycles"}, n_crst, CLR);
        check({tag, "_elapsed"}, o_elapsed, ee);
        check({tag, "_done"}, o_status[6], 1);
        check({tag, "_aborted"}, o_status[7], 0);
        check({tag, "_busy"}, o_status[5], 0);
        check_snaps(tag);
    endtask

    task automatic do_abort(input int k, input string tag);
        i_duration = 20; clear_mon();
        pulse(0);
        repeat (k - 2) @(negedge clk);
        pulse(1);
        check({tag, "_state"}, o_status[3:0], 0);
        check({tag, "_crst"}, o_mon_counter_reset, 0);
        check({tag, "_aborted"}, o_status[7], 1);
        repeat (40) @(negedge clk);
        check({tag, "_nstart"}, q_start.size(), 0);
        check({tag, "_nstop"}, q_stop.size(), 0);
        check({tag, "_ncap"}, q_cap.size(), 0);
        check({tag, "_done"}, o_status[6], 0);
        check_snaps(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, {o_mon_start, o_mon_stop, o_mon_counter_reset}, 0);
        check({tag, "_status"}, o_status, 0);
        check({tag, "_elapsed"}, o_elapsed, 0);
        check({tag, "_runcnt"}, o_run_count, 0);
        check({tag, "_snaps"}, {o_snap_bw_rd, o_snap_bw_wr, o_snap_lat_avg, o_snap_lat_max, o_snap_lat_min}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int d;
        rst_n = 1'b0; i_cmd_start = 0; i_cmd_stop = 0; i_cmd_clear = 0; i_continuous = 0;
        i_duration = 0; set_data(0);
        model_zero();
        tbl[0] = '{100, 32'h0012_3456, 5, 106, 122, 100};
        tbl[1] = '{1,   32'hDEAD_BEEF, 5, 7,   23,  1};
        tbl[2] = '{2,   32'h0000_0001, 5, 8,   24,  2};
        tbl[3] = '{37,  32'hFFFF_FFFF, 5, 43,  59,  37};
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            do_run(tbl[i].dur, tbl[i].bw_rd, tbl[i].exp_start, tbl[i].exp_stop,
                   tbl[i].exp_cap, tbl[i].exp_elapsed, $sformatf("tbl%0d", i));

        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(1, 80);
            do_run(d, $urandom, CLR + 1, CLR + 1 + d + 1, CLR + 1 + d + 1 + SET, d, $sformatf("rnd%0d", i));
        end

        // Open-ended run stopped by command 500 cycles into RUN.
        i_duration = 0; set_data(32'hCAFE_0000); clear_mon();
        pulse(0);
        wait_starts(1, 50, ok);
        check("dur0_started", ok, 1);
        repeat (498) @(negedge clk);
        pulse(1);
        wait_idle(100, ok);
        check("dur0_done_in_time", ok, 1);
        model_capture();
        check("dur0_elapsed", o_elapsed, 500);
        check("dur0_nstop", q_stop.size(), 1);
        check("dur0_ncap", q_cap.size(), 1);
        check("dur0_stop_lat", qat(q_stop, 0) - t_start, CLR + 1 + 500 + 1);
        check_snaps("dur0");

        // Continuous mode: three full captures, stop during the fourth RUN.
        i_continuous = 1'b1; i_duration = 50; set_data(32'h0BAD_F00D); clear_mon();
        pulse(0);
        wait_starts(4, 1000, ok);
        check("cont_reach4", ok, 1);
        check("cont_ncap3", q_cap.size(), 3);
        check("cont_latched", o_status[4], 1);
        repeat (8) @(negedge clk);
        pulse(1);
        wait_idle(200, ok);
        check("cont_done_in_time", ok, 1);
        for (int i = 0; i < 4; i++) model_capture();
        check("cont_ncap", q_cap.size(), 4);
        check("cont_nstart", q_start.size(), 4);
        check("cont_nstop", q_stop.size(), 4);
        check("cont_run1_len", qat(q_stop, 0) - qat(q_start, 0), 51);
        check("cont_restart_gap", qat(q_start, 1) - qat(q_cap, 0), CLR + 2);
        check("cont_run4_len", qat(q_stop, 3) - qat(q_start, 3), 11);
        check("cont_elapsed", o_elapsed, 10);
        check("cont_latched_end", o_status[4], 0);
        check_snaps("cont");
        i_continuous = 1'b0;
        repeat (30) @(negedge clk);
        check("cont_no_restart", q_start.size(), 4);

        do_abort(2, "abort_clr");
        do_abort(5, "abort_arm");

        // Start and stop together in IDLE: stop wins.
        clear_mon();
        @(negedge clk); i_cmd_start = 1'b1; i_cmd_stop = 1'b1;
        @(negedge clk); i_cmd_start = 1'b0; i_cmd_stop = 1'b0;
        check("startstop_state", o_status[3:0], 0);
        repeat (10) @(negedge clk);
        check("startstop_crst", n_crst, 0);
        check("startstop_nstart", q_start.size(), 0);

        // Clear during RUN is ignored; clear in IDLE wipes results.
        i_duration = 30; set_data(32'h5555_AAAA); clear_mon();
        pulse(0);
        repeat (15) @(negedge clk);
        pulse(2);
        wait_idle(200, ok);
        check("clrrun_done_in_time", ok, 1);
        model_capture();
        check_snaps("clrrun");
        pulse(2);
        model_zero();
        check_snaps("clridle");
        check("clridle_done", o_status[6], 0);

        // One-cycle reset in the middle of RUN.
        i_duration = 0; set_data(32'h7777_0001); clear_mon();
        pulse(0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_elapsed == 37) begin ok = 1'b1; break; end
        end
        check("rstrun_reach37", ok, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_zero();
        check_all_zero("rstrun");
        repeat (30) @(negedge clk);
        check("rstrun_nstop", q_stop.size(), 0);
        check("rstrun_state", o_status[3:0], 0);
        do_run(10, 32'h1234_5678, CLR + 1, CLR + 12, CLR + 12 + SET, 10, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_perf_mon_ctrl.md
Name: axi_perf_mon_ctrl

Overview:
Measurement sequencer for one AXI performance monitor instance (bandwidth plus latency).
- Accepts start/stop/clear commands from the user register block.
- Drives the monitor's start, stop and counter-reset strobes through a fixed clear→run→stop→settle→capture sequence.
- Latches the monitor's result registers into stable snapshot registers for software readback.
- Supports single-shot and continuous (auto-repeat) measurement.

Parameters:
- CLR_CYCLES, 4: cycles o_mon_counter_reset is held high before each run (1..15).
- SETTLE_CYCLES, 16: cycles waited after o_mon_stop before capture, so monitor pipelines drain (1..255).
- DUR_WIDTH, 32: width of the duration and elapsed-cycle counters.

Ports:
- i_clk  in  1  clock; same domain as the monitored AXI interface.
- i_reset_n  in  1  reset; synchronous, active-low.
- i_cmd_start  in  1  single-cycle pulse: begin a measurement.
- i_cmd_stop  in  1  single-cycle pulse: end or abort a measurement.
- i_cmd_clear  in  1  single-cycle pulse: clear snapshots and run count (honoured only in IDLE).
- i_continuous  in  1  1 = restart automatically after each capture; sampled in CAPTURE.
- i_duration  in  DUR_WIDTH  run length in cycles; 0 = run until i_cmd_stop; sampled on accepted start.
- i_bw_rd, i_bw_wr  in  32 each  monitor bandwidth result registers.
- i_lat_avg, i_lat_max, i_lat_min  in  32 each  monitor latency result registers.
- o_mon_start  out  1  one-cycle pulse to the monitor's start input.
- o_mon_stop  out  1  one-cycle pulse to the monitor's stop input.
- o_mon_counter_reset  out  1  level to the monitor's counter-reset input.
- o_snap_bw_rd, o_snap_bw_wr, o_snap_lat_avg, o_snap_lat_max, o_snap_lat_min  out  32 each  captured results.
- o_elapsed  out  DUR_WIDTH  cycles spent in RUN during the last or current run.
- o_run_count  out  16  completed captures; saturates at 16'hFFFF.
- o_status  out  32  {24'b0, aborted, done, busy, continuous_latched, state[3:0]}.

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - state = IDLE; all outputs 0; o_mon_counter_reset = 0.
  - Reset mid-run drops o_mon_counter_reset immediately.
  - No stop pulse is issued on reset.
- States are IDLE, CLEAR, ARM, RUN, STOP, SETTLE, CAPTURE. Encoding is 0..6 in o_status[3:0].
- IDLE:
  - i_cmd_start (without i_cmd_stop) goes to CLEAR. It latches i_duration, clears o_elapsed and clears aborted and done.
  - If start and stop arrive in the same cycle, stop wins; stay in IDLE.
  - i_cmd_clear zeroes all snapshots, o_run_count and done.
- CLEAR:
  - o_mon_counter_reset = 1 for exactly CLR_CYCLES cycles, then go to ARM.
- ARM:
  - o_mon_start = 1 for one cycle, then go to RUN.
- RUN:
  - o_elapsed increments every cycle and saturates at all-ones.
  - Leave for STOP when o_elapsed reaches latched duration − 1 (duration ≠ 0), or when i_cmd_stop arrives.
  - duration = 1 gives exactly 1 RUN cycle.
- STOP:
  - o_mon_stop = 1 for one cycle, then go to SETTLE.
- SETTLE:
  - Wait SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - All five snapshot registers load their inputs simultaneously.
  - o_run_count increments (saturating) and done = 1.
  - If i_continuous = 1 and no i_cmd_stop is seen this cycle, go to CLEAR (i_duration is re-sampled). Otherwise go to IDLE.
- Stop in CLEAR or ARM: abort to IDLE.
  - No o_mon_start is issued (if in ARM, the stop takes priority over the start pulse).
  - aborted = 1; no capture; o_mon_counter_reset drops on the next cycle.
- Stop in STOP, SETTLE or CAPTURE: records a request to end continuous mode. The sequence still completes and captures, then returns to IDLE.
- i_cmd_start outside IDLE is ignored. i_cmd_clear outside IDLE is ignored.
- busy = (state ≠ IDLE).
- Latency for a duration-D run:
  - start pulse → o_mon_start = CLR_CYCLES + 1 cycles.
  - start pulse → capture = CLR_CYCLES + 1 + D + 1 + SETTLE_CYCLES cycles.
- All outputs are registered.

Decomposition:
- Shared package axi_perf_mon_pkg:
  - state enum t_pmc_state (4-bit);
  - status bit index constants;
  - snapshot struct t_pmc_snapshot (five 32-bit fields).
- One sub-module, axi_perf_mon_snapshot: five 32-bit capture registers with load and clear, plus the saturating run counter.
- The FSM and its counters stay in the top-level module.

Test Plan:
- Single shot, CLR=4, SETTLE=16, duration=100, i_bw_rd=32'h0012_3456:
  - o_mon_start asserts 5 cycles after start;
  - o_mon_stop is 101 cycles after o_mon_start;
  - o_snap_bw_rd = 32'h0012_3456;
  - o_run_count = 1, o_elapsed = 100, done = 1, busy = 0.
- Duration=0, stop pulse 500 cycles after o_mon_start:
  - o_elapsed = 500;
  - exactly one o_mon_stop and one capture.
- Continuous, duration=50: three captures occur, then stop is pulsed during the 4th RUN.
  - o_run_count = 4, ending in IDLE.
  - Stop during the 5th CLEAR is never reached.
- Abort: stop 2 cycles after start (in CLEAR):
  - no o_mon_start; aborted = 1;
  - snapshots and o_run_count unchanged.
- Simultaneous start+stop in IDLE leaves the state at IDLE. Then i_cmd_clear after 2 runs gives o_run_count = 0 and snapshots = 0. A clear while in RUN is ignored.
- i_reset_n low for 1 cycle mid-RUN (elapsed=37):
  - all outputs return to 0 on the next cycle;
  - no o_mon_stop is emitted;
  - a new start then runs normally.
